// File: rtl/regfile_param.sv
// Parametrised 2R1W register file with a hardware clear sweep after reset or on request.
// Optional write-to-read forwarding is compiled in with REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ADDR_W   = $clog2(NREGS),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  typedef enum logic {StClear, StRun} state_e;

  localparam logic [ADDR_W:0] CntLast = (ADDR_W + 1)'(NREGS - 1);

  state_e            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] rf_q [NREGS];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (cnt_q == CntLast) begin
            state_q <= StRun;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (clr_req) begin
            state_q <= StClear;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StClear;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Sweep owns the write port in CLEAR; a clear request beats a same-edge write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q[ADDR_W-1:0];
    end else if (we && !clr_req && !((ZERO_REG != 0) && (wa == '0))) begin
      wr_en   = 1'b1;
      wr_addr = wa;
      wr_data = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd1 = '0;
    if ((state_q == StRun) && !((ZERO_REG != 0) && (ra1 == '0))) begin
      rd1 = rf_q[ra1];
`ifdef REGFILE_BYPASS_EN
      if (we && (wa == ra1)) begin
        rd1 = wd;
      end
`endif
    end
  end

  always_comb begin
    rd2 = '0;
    if ((state_q == StRun) && !((ZERO_REG != 0) && (ra2 == '0))) begin
      rd2 = rf_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (we && (wa == ra2)) begin
        rd2 = wd;
      end
`endif
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: a 32-entry ZERO_REG=1 file and an 8-entry ZERO_REG=0 file share stimulus
// and are compared each cycle against an array model, plus directed literal checks.
module tb_regfile_param;

  logic        clk;
  logic        rst_n;
  logic        clr_req;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        ready0, ready1;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;

  int errors = 0;
  int checks = 0;

  regfile_param #(.DATA_W(32), .NREGS(32), .ZERO_REG(1)) u_rf0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready0), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0)
  );

  regfile_param #(.DATA_W(32), .NREGS(8), .ZERO_REG(0)) u_rf1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready1), .we(we), .wa(wa[2:0]),
    .wd(wd), .ra1(ra1[2:0]), .ra2(ra2[2:0]), .rd1(rd1_1), .rd2(rd2_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: ready after n edges of CLEAR; whole array is zero once ready rises.
  logic [31:0] m_mem [2][32];
  bit          m_ready [2];
  int          m_left [2];

  function automatic int nregs(int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic bit zreg(int k);
    return (k == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ready[k] <= 1'b0;
        m_left[k]  <= nregs(k);
      end else if (!m_ready[k]) begin
        if (m_left[k] == 1) begin
          m_ready[k] <= 1'b1;
          for (int j = 0; j < 32; j++) m_mem[k][j] <= 32'h0;
        end
        m_left[k] <= m_left[k] - 1;
      end else if (clr_req) begin
        m_ready[k] <= 1'b0;
        m_left[k]  <= nregs(k);
      end else if (we && !(zreg(k) && (int'(wa) % nregs(k)) == 0)) begin
        m_mem[k][int'(wa) % nregs(k)] <= wd;
      end
    end
  end

  function automatic logic [31:0] exp_rd(int k, logic [4:0] ra);
    int a;
    a = int'(ra) % nregs(k);
    if (!m_ready[k]) return 32'h0;
    if (zreg(k) && a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && (int'(wa) % nregs(k)) == a) return wd;
`endif
    return m_mem[k][a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("ready0", {31'h0, ready0}, {31'h0, m_ready[0]});
    check("ready1", {31'h0, ready1}, {31'h0, m_ready[1]});
    check("rd1_0", rd1_0, exp_rd(0, ra1));
    check("rd2_0", rd2_0, exp_rd(0, ra2));
    check("rd1_1", rd1_1, exp_rd(1, ra1));
    check("rd2_1", rd2_1, exp_rd(1, ra2));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd3; ra2 = 5'd9;
    step(); step();
    #1;
    check("rst_ready", {31'h0, ready0}, 32'h0);
    check("rst_rd1", rd1_0, 32'h0);
    check("rst_rd2", rd2_0, 32'h0);
    rst_n = 1'b1;

    repeat (31) step();
    #1 check("sweep_31_ready", {31'h0, ready0}, 32'h0);
    check("sweep_31_rd1", rd1_0, 32'h0);
    step();
    #1 check("sweep_32_ready", {31'h0, ready0}, 32'h1);

    for (int i = 0; i < 32; i += 2) begin
      ra1 = 5'(i); ra2 = 5'(i + 1);
      #1;
      check("cleared_rd1", rd1_0, 32'h0);
      check("cleared_rd2", rd2_0, 32'h0);
      step();
    end

    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    step();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    #1 check("r5_rd1", rd1_0, 32'hDEADBEEF);
    check("r5_rd2", rd2_0, 32'hDEADBEEF);

    we = 1'b1; wa = 5'd0; wd = 32'h12345678;
    step();
    we = 1'b0; ra1 = 5'd0;
    #1 check("r0_zero_reg", rd1_0, 32'h0);
    check("r0_plain_reg", rd1_1, 32'h12345678);

    we = 1'b1; wa = 5'd7; wd = 32'h1;
    step();
    wd = 32'hA5A5A5A5; ra1 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    #1 check("bypass_same_cycle", rd1_0, 32'hA5A5A5A5);
`else
    #1 check("nobypass_same_cycle", rd1_0, 32'h1);
`endif
    step();
    we = 1'b0;
    #1 check("write_next_cycle", rd1_0, 32'hA5A5A5A5);

    we = 1'b1; wa = 5'd3; wd = 32'h99;
    step();
    clr_req = 1'b1; wa = 5'd3; wd = 32'h55;
    step();
    clr_req = 1'b0; wd = 32'h77;
    #1 check("clr_ready_fell", {31'h0, ready0}, 32'h0);
    repeat (31) step();
    #1 check("clr_32_ready", {31'h0, ready0}, 32'h0);
    step();
    we = 1'b0; ra1 = 5'd3;
    #1 check("clr_33_ready", {31'h0, ready0}, 32'h1);
    check("clr_r3", rd1_0, 32'h0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    rst_n = 1'b0;
    #1 check("midsweep_ready", {31'h0, ready0}, 32'h0);
    #1 rst_n = 1'b1;
    repeat (31) step();
    #1 check("midsweep_31_ready", {31'h0, ready0}, 32'h0);
    step();
    #1 check("midsweep_32_ready", {31'h0, ready0}, 32'h1);

    for (int i = 0; i < 600; i++) begin
      step();
      we      = 1'($urandom_range(0, 1));
      wa      = 5'($urandom);
      wd      = $urandom;
      ra1     = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      ra2     = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      clr_req = ($urandom_range(0, 59) == 0);
    end
    step();
    we = 1'b0; clr_req = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
